branch_predictor_bht: RTL and testbench

- Parametrised branch history table of 2^INDEX_BITS saturating counters, indexed by PC, replacing the single-counter predictor in the ID stage.
- Combinational lookup gives a taken/not-taken prediction for a decoded branch.
- A resolve port from EX trains the addressed counter and keeps saturating statistics counters for branches and mispredictions.

---
 rtl/branch_predictor_bht.sv | 118 +++++++++++
 tb/tb_branch_predictor_bht.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Branch history table: 2^INDEX_BITS saturating counters indexed by word PC.
// Optional gshare indexing is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pred_valid/pred_pc  ID-stage lookup request
//   pred_taken          combinational prediction (registered table state only)
//   upd_valid/upd_pc    EX-stage resolve of a conditional branch
//   upd_taken/upd_pred  actual outcome / prediction originally issued
//   stat_branches       saturating count of resolved branches
//   stat_mispred        saturating count of mispredicted resolves
module branch_predictor_bht #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned INIT_CNT   = 1,
  parameter int unsigned STAT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_taken,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_pred,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispred
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic [CNT_BITS-1:0]   cnt_q [ENTRIES];
  logic [CNT_BITS-1:0]   upd_cnt;
  logic [CNT_BITS-1:0]   upd_cnt_d;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [STAT_BITS-1:0]  branches_q, branches_d;
  logic [STAT_BITS-1:0]  mispred_q, mispred_d;

  // Byte-offset and upper PC bits never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_BITS+2], pred_pc[1:0],
                            upd_pc[PC_WIDTH-1:INDEX_BITS+2],  upd_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  // Both lookup and update hash with the history as it stands before this resolve.
  assign pred_idx = pred_pc[INDEX_BITS+1:2] ^ ghr_q;
  assign upd_idx  = upd_pc[INDEX_BITS+1:2] ^ ghr_q;

  // Shift in the resolved outcome; truncation drops the oldest bit (works for INDEX_BITS=1).
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = INDEX_BITS'({ghr_q, upd_taken});
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign pred_idx = pred_pc[INDEX_BITS+1:2];
  assign upd_idx  = upd_pc[INDEX_BITS+1:2];
`endif

  // No bypass: lookup sees the table as registered at the last edge.
  assign pred_taken = pred_valid & cnt_q[pred_idx][CNT_BITS-1];

  // Saturating train value for the addressed entry.
  always_comb begin
    upd_cnt   = cnt_q[upd_idx];
    upd_cnt_d = upd_cnt;
    if (upd_taken) begin
      if (upd_cnt != CNT_MAX) upd_cnt_d = upd_cnt + CNT_BITS'(1);
    end else begin
      if (upd_cnt != '0)      upd_cnt_d = upd_cnt - CNT_BITS'(1);
    end
  end

  // Saturating statistics.
  always_comb begin
    branches_d = branches_q;
    mispred_d  = mispred_q;
    if (upd_valid) begin
      if (branches_q != STAT_MAX) branches_d = branches_q + STAT_BITS'(1);
      if ((upd_pred != upd_taken) && (mispred_q != STAT_MAX))
        mispred_d = mispred_q + STAT_BITS'(1);
    end
  end

  // Table state; reset wins over a concurrent resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_BITS'(INIT_CNT);
    end else if (upd_valid) begin
      cnt_q[upd_idx] <= upd_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= '0;
      mispred_q  <= '0;
    end else begin
      branches_q <= branches_d;
      mispred_q  <= mispred_d;
    end
  end

  assign stat_branches = branches_q;
  assign stat_mispred  = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht (STAT_BITS=4 to reach stat saturation).
module tb_branch_predictor_bht;

  localparam int unsigned SB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic          upd_pred;
  logic [SB-1:0] stat_branches;
  logic [SB-1:0] stat_mispred;

  branch_predictor_bht #(
    .PC_WIDTH(32), .INDEX_BITS(4), .CNT_BITS(2), .INIT_CNT(1), .STAT_BITS(SB)
  ) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          pt;
    logic [SB-1:0] br;
    logic [SB-1:0] mis;
  } exp_t;

  exp_t sb_q[$];
  logic obs = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Monitor: whenever an observation is presented, pop and compare.
  always @(negedge clk) begin
    if (obs) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: observation with no expected entry");
      end else begin
        e = sb_q.pop_front();
        total++;
        if (pred_taken !== e.pt) begin
          bad++;
          $display("FAIL %s pred_taken got=%0b exp=%0b", e.name, pred_taken, e.pt);
        end
        total++;
        if (stat_branches !== e.br) begin
          bad++;
          $display("FAIL %s stat_branches got=%0d exp=%0d", e.name, stat_branches, e.br);
        end
        total++;
        if (stat_mispred !== e.mis) begin
          bad++;
          $display("FAIL %s stat_mispred got=%0d exp=%0d", e.name, stat_mispred, e.mis);
        end
      end
    end
  end

  // One cycle of stimulus; optional expectation for the state seen in this cycle.
  task automatic step(input logic r, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic up, input logic pv,
                      input logic [31:0] ppc, input logic chk, input logic ept,
                      input int ebr, input int emis, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred = up;
    pred_valid = pv; pred_pc = ppc;
    if (chk) begin
      e.name = nm; e.pt = ept; e.br = SB'(ebr); e.mis = SB'(emis);
      sb_q.push_back(e);
    end
    obs = chk;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic p);
    step(1'b0, 1'b1, pc, t, p, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, "");
  endtask

  task automatic look(input logic [31:0] pc, input logic ept, input int ebr,
                      input int emis, input string nm);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc, 1'b1, ept, ebr, emis, nm);
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0;
    pred_valid = 1'b0; pred_pc = '0;

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    // Reset state: cnt=1 -> not taken, stats zero.
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 32'h40, 1'b1, 1'b0, 0, 0, "reset_pred");
    // Train 0x40 taken; same-cycle lookup sees pre-update value.
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 0, 0, "upd1_same_cycle");
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1, 1, "upd1_visible");
    look(32'h40, 1'b1, 2, 2, "upd2");
    look(32'h44, 1'b0, 2, 2, "isolation");
    step(1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h40, 1'b1, 1'b0, 2, 2, "pred_valid_low");
    // Disabled resolve with live-looking operands must not disturb state.
    step(1'b0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 2, 2, "hold_no_upd");
    look(32'h40, 1'b1, 2, 2, "hold_check");
    // Saturation high at 0x08 (idx 2).
    for (int i = 0; i < 5; i++) upd(32'h08, 1'b1, 1'b1);
    look(32'h08, 1'b1, 7, 2, "sat_hi");
    upd(32'h08, 1'b0, 1'b1);
    look(32'h08, 1'b1, 8, 3, "dec_from_sat");
    upd(32'h08, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) upd(32'h08, 1'b0, 1'b0);
    look(32'h08, 1'b0, 13, 3, "sat_lo");
    upd(32'h08, 1'b1, 1'b1);
    look(32'h08, 1'b0, 14, 3, "no_wrap");
    // Aliasing 0x04/0x44 on idx 1, with old-value-this-cycle behaviour.
    step(1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 14, 3, "alias_pre");
    step(1'b0, 1'b1, 32'h04, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 15, 4, "alias_flip");
    look(32'h44, 1'b1, 15, 5, "alias_post");
    // Statistics saturation.
    for (int i = 0; i < 5; i++) upd(32'h80, 1'b1, 1'b0);
    look(32'h80, 1'b1, 15, 10, "stat_sat");
    for (int i = 0; i < 6; i++) upd(32'h80, 1'b1, 1'b0);
    look(32'h80, 1'b1, 15, 15, "mis_sat");
    // Reset beats a concurrent resolve.
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0, "");
    look(32'h40, 1'b0, 0, 0, "rst_prio");
    look(32'h44, 1'b0, 0, 0, "rst_clears_alias");
    upd(32'h44, 1'b1, 1'b0);
    look(32'h44, 1'b1, 1, 1, "post_rst_train");
`else
    step(1'b1, 1'b0, 0, 0, 0, 1'b1, 32'h40, 1'b1, 1'b0, 0, 0, "reset_pred");
    upd(32'h00, 1'b1, 1'b0);
    upd(32'h00, 1'b1, 1'b0);
    look(32'h0C, 1'b1, 2, 2, "gshare_idx0");
    look(32'h08, 1'b1, 2, 2, "gshare_idx1");
    look(32'h00, 1'b0, 2, 2, "gshare_idx3");
`endif

    step(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0, "");
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
